data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Data-side memory slave for the RISC-V core's load/store path.
//  Accepts one request at a time over a valid/ready handshake and applies byte-lane writes.
//  Returns read data and an error flag after a programmable number of wait states.
//  Sits opposite the core's load/store requester, next to InstructionMemory.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//  WAIT_STATES  2    extra cycles between accept and response (0 allowed)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept (high only in IDLE)
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, lane-aligned
//  req_be      in   4   byte enables; bit i covers wdata[8i+7:8i]
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   requester takes the response
//  rsp_rdata   out  32  load data; full word regardless of be; 0 on stores and errors
//  rsp_err     out  1   misaligned or out-of-range access
//  busy        out  1   high in WAIT or RESP
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//  - state <= IDLE; rsp_valid, rsp_err, rsp_rdata and busy <= 0.
//  - req_ready is low while reset is held and high from the first cycle after release.
//  - Any in-flight request is dropped. An uncommitted store is never written.
//  - Array contents are not cleared.
//  FSM states (mem_state_t): IDLE, WAIT, RESP.
//  - IDLE: req_ready=1. On req_valid&&req_ready at edge N, latch write/addr/wdata/be and load cnt=WAIT_STATES.
//    Go to WAIT, or go straight to RESP if WAIT_STATES==0.
//  - WAIT: decrement cnt each cycle. On the edge where cnt==1, perform the access and go to RESP.
//  - RESP: rsp_valid=1. rdata and err stay stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
//    req_ready rises the next cycle, so there are no back-to-back accepts.
//  Access and latency:
//  - The access (read sample or store commit) happens on the edge that enters RESP.
//  - rsp_valid is first high in cycle N+WAIT_STATES+1.
//  Error checks:
//  - err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH_WORDS).
//  - On error: no array access, rsp_rdata=0, rsp_err=1.
//  Store rules:
//  - Only lanes with be[i]=1 change.
//  - be==0 is a legal no-op store: err=0, rdata=0.
//  Read rules:
//  - A load after a store to the same word returns the stored data (no forwarding needed; accesses are serialized).
//  Request handling outside IDLE:
//  - req_* inputs are ignored.
//  - The requester must hold req_valid and its payload stable until accepted.
//  Address width:
//  - Word index uses addr[$clog2(DEPTH_WORDS)+1:2].
//  - Upper bits take part only in the range check and never wrap into the array.
// STRUCTURE
//  TypesPkg: add mem_state_t enum (IDLE, WAIT, RESP) and the MEM_WORD_BYTES=4 constant.
//  Sub-module data_mem_array (DEPTH_WORDS):
//  - sync write with 4 byte enables; async read; no reset.
//  - The responder owns the FSM, wait counter, request latch and error logic.
// TESTING
//  1. Reset with reset=0 for 2 cycles mid-WAIT of a store (0x10 <= 0xDEADBEEF)
//     -> rsp_valid=0, req_ready=1 after release, and a later load of 0x10 does not return 0xDEADBEEF.
//  2. Store 0x04 <= 0x11223344, be=4'b1111, then load 0x04 with WAIT_STATES=2
//     -> each rsp_valid appears 3 cycles after accept; load rdata=0x11223344, err=0.
//  3. Store 0x04 <= 0xAABBCCDD, be=4'b0101, over 0x11223344
//     -> next load 0x04 returns 0x11BB33DD.
//  4. Load 0x06 (misaligned) and load 0x400 with DEPTH_WORDS=256
//     -> rsp_err=1, rsp_rdata=0, array unchanged.
//  5. Hold rsp_ready=0 for 5 cycles in RESP
//     -> rsp_valid, rdata and err stay stable, req_ready=0, new req_valid is ignored.
//     Release -> IDLE the next cycle.
//  6. WAIT_STATES=0 with requests back-to-back and rsp_ready tied to 1
//     -> accept every 2 cycles, response 1 cycle after accept, busy toggling 0/1.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the data-side memory responder.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int MEM_WORD_BYTES = 4;

  // Misaligned or beyond the last word; upper address bits never wrap into the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage with per-byte write enables, synchronous write and asynchronous read.
module data_mem_array
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [MEM_WORD_BYTES-1:0]   be,
  input  logic [AW-1:0]               addr,
  input  logic [8*MEM_WORD_BYTES-1:0] wdata,
  output logic [8*MEM_WORD_BYTES-1:0] rdata
);

  logic [8*MEM_WORD_BYTES-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MEM_WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// Load/store memory slave: one request at a time, programmable wait states,
// byte-lane stores, and an error flag for misaligned or out-of-range accesses.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic        accept;
  logic        enter_resp;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign accept = req_valid && req_ready;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request rather than the latch that is only being loaded.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign enter_resp = ((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && (cnt == CNT_W'(1)));
  assign acc_err    = addr_err(acc_addr, DEPTH_WORDS);
  assign mem_we     = reset && enter_resp && acc_write && !acc_err;

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (acc_be),
    .addr (acc_addr[AW+1:2]),
    .wdata(acc_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= CNT_W'(WAIT_STATES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Overrides the WAIT transition above when no wait states are configured.
      if (enter_resp) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_write || acc_err) ? 32'h0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed table, multi-cycle corner sequences,
// and randomized traffic against a word-array reference model.
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        req_valid_z, req_ready_z, req_write_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [3:0]  req_be_z;
  logic        rsp_valid_z, rsp_ready_z, rsp_err_z, busy_z;
  logic [31:0] rsp_rdata_z;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [256];

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z), .busy(busy_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, input logic [31:0] er, input logic ee);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.be = b; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Reference: byte-addressed memory of 256 words; anything unaligned or past 1 KiB is an error.
  task automatic model_access(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rdata, output logic err);
    err   = (addr % 4 != 0) || (addr / 4 >= 256);
    rdata = 32'h0;
    if (!err) begin
      if (write) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model_mem[addr / 4][8*i +: 8] = wdata[8*i +: 8];
        end
      end else begin
        rdata = model_mem[addr / 4];
      end
    end
  endtask

  task automatic do_req(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = write; req_addr = addr; req_wdata = wdata; req_be = be;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no req_ready, want req_ready within 50 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_checked(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input string name);
    logic [31:0] exp_rdata, got_rdata;
    logic        exp_err, got_err;
    int          lat;
    model_access(write, addr, wdata, be, exp_rdata, exp_err);
    do_req(write, addr, wdata, be, got_rdata, got_err, lat);
    chk({name, "_rdata"}, got_rdata, exp_rdata);
    chk({name, "_err"}, 32'(got_err), 32'(exp_err));
    chk({name, "_latency"}, lat, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got_rdata, dummy_rdata, v;
    logic        got_err, dummy_err, wr;
    logic [31:0] addr;
    int          lat, n, mode;

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
    rsp_ready_z = 1'b1;

    // Reset state and release
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("release_req_ready", 32'(req_ready), 1);
    chk("release_z_req_ready", 32'(req_ready_z), 1);

    // Reset in the middle of a store's wait: the store must never land
    run_checked(1'b1, 32'h10, 32'h01020304, 4'hF, "pre_store");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
    chk("midwait_ready_before_accept", 32'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midwait_busy", 32'(busy), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_rsp_valid", 32'(rsp_valid), 0);
    chk("midreset_req_ready", 32'(req_ready), 1);
    chk("midreset_busy", 32'(busy), 0);
    run_checked(1'b0, 32'h10, 32'h0, 4'h0, "load_after_reset");

    // Give every word a known value
    for (int w = 0; w < 256; w++) begin
      run_checked(1'b1, 32'(w * 4), $urandom, 4'hF, $sformatf("init%0d", w));
    end

    // Directed table
    tbl.push_back(mk(1'b1, 32'h04,       32'h11223344, 4'hF, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h04,       32'h0,        4'h0, 32'h11223344, 1'b0));
    tbl.push_back(mk(1'b1, 32'h04,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h04,       32'h0,        4'h0, 32'h11BB33DD, 1'b0));
    tbl.push_back(mk(1'b0, 32'h06,       32'h0,        4'h0, 32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 32'h400,      32'h0,        4'h0, 32'h0,        1'b1));
    tbl.push_back(mk(1'b1, 32'h400,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1));
    tbl.push_back(mk(1'b1, 32'h06,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1));
    tbl.push_back(mk(1'b1, 32'h10000004, 32'h00000000, 4'hF, 32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 32'h10000004, 32'h0,        4'h0, 32'h0,        1'b1));
    tbl.push_back(mk(1'b0, 32'h04,       32'h0,        4'h0, 32'h11BB33DD, 1'b0));
    tbl.push_back(mk(1'b1, 32'h08,       32'hCAFEBABE, 4'hF, 32'h0,        1'b0));
    tbl.push_back(mk(1'b1, 32'h08,       32'h12345678, 4'h0, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h08,       32'h0,        4'h0, 32'hCAFEBABE, 1'b0));
    tbl.push_back(mk(1'b1, 32'h3FC,      32'h55AA55AA, 4'hF, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 32'h3FC,      32'h0,        4'h0, 32'h55AA55AA, 1'b0));
    tbl.push_back(mk(1'b0, 32'h3FF,      32'h0,        4'h0, 32'h0,        1'b1));
    for (int i = 0; i < tbl.size(); i++) begin
      model_access(tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].be, dummy_rdata, dummy_err);
      do_req(tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].be, got_rdata, got_err, lat);
      chk($sformatf("tbl%0d_rdata", i), got_rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), 32'(got_err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_latency", i), lat, 3);
    end

    // Backpressure in RESP while a competing request is presented
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h04; req_wdata = 32'h0; req_be = 4'h0;
    chk("bp_ready_before_accept", 32'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_timeout", 32'(n < 50), 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 1);
      chk($sformatf("bp%0d_rdata", k), rsp_rdata, 32'h11BB33DD);
      chk($sformatf("bp%0d_err", k), 32'(rsp_err), 0);
      chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 0);
      chk($sformatf("bp%0d_busy", k), 32'(busy), 1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_rsp_valid", 32'(rsp_valid), 0);
    chk("bp_release_req_ready", 32'(req_ready), 1);
    chk("bp_release_busy", 32'(busy), 0);
    run_checked(1'b0, 32'h04, 32'h0, 4'h0, "bp_ignored_store");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0)      addr = (32'($urandom_range(0, 1023)) & ~32'h3) | 32'($urandom_range(1, 3));
      else if (mode == 1) addr = $urandom | 32'h400;
      else                addr = 32'($urandom_range(0, 255)) * 4;
      wr = 1'($urandom_range(0, 1));
      run_checked(wr, addr, $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i));
    end

    // Zero wait states, continuous requests, response always taken
    @(negedge clk);
    req_valid_z = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 32'h01010101 * 32'(i + 1);
      chk($sformatf("ws0_%0d_ready", i), 32'(req_ready_z), 1);
      chk($sformatf("ws0_%0d_busy_idle", i), 32'(busy_z), 0);
      chk($sformatf("ws0_%0d_rsp_idle", i), 32'(rsp_valid_z), 0);
      req_write_z = (i % 2 == 0);
      req_addr_z  = 32'h20;
      req_wdata_z = (i % 2 == 0) ? v : 32'h0;
      req_be_z    = (i % 2 == 0) ? 4'hF : 4'h0;
      @(negedge clk);
      chk($sformatf("ws0_%0d_rsp_valid", i), 32'(rsp_valid_z), 1);
      chk($sformatf("ws0_%0d_busy", i), 32'(busy_z), 1);
      chk($sformatf("ws0_%0d_ready_low", i), 32'(req_ready_z), 0);
      chk($sformatf("ws0_%0d_err", i), 32'(rsp_err_z), 0);
      chk($sformatf("ws0_%0d_rdata", i), rsp_rdata_z,
          (i % 2 == 0) ? 32'h0 : 32'h01010101 * 32'(i));
      @(negedge clk);
    end
    req_write_z = 1'b0; req_addr_z = 32'h22; req_be_z = 4'h0;
    @(negedge clk);
    chk("ws0_misaligned_err", 32'(rsp_err_z), 1);
    chk("ws0_misaligned_rdata", rsp_rdata_z, 0);
    req_valid_z = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
